program_loader: RTL

Boot-time writer for the CPU's instruction memory. Accepts a framed byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and issues one write per word into the instruction store. It also holds the CPU in reset until a complete, valid image has been written. It sits between the host link and the `instruction` memory's write port, alongside `risc_v_cpu`.

---
 rtl/program_loader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/program_loader.sv
// Boot loader: framed byte stream (A5, LEN16, N LE words[, xor checksum]) -> instruction-memory writes; holds CPU until done.
// Latency: imem_we rises the cycle after a word's 4th byte; done follows the last write by >= 1 cycle.
// Backpressure: in_ready drops during WRITE, DONE, ERROR and while start/reset is high. Checksum via PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_address,
  output logic [31:0] imem_data,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);
  localparam int IW = $clog2(MAX_WORDS + 1);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CHECK, DONE, ERROR} state_t;
  localparam state_t TAIL = CHECK;
`else
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERROR} state_t;
  localparam state_t TAIL = DONE;
`endif

  state_t        state, state_nxt;
  logic [7:0]    len_lo, len_lo_nxt;
  logic [IW-1:0] len_q, len_nxt;
  logic [IW-1:0] word_index, word_index_nxt;
  logic [1:0]    byte_cnt, byte_cnt_nxt;
  logic [23:0]   word_buf, word_buf_nxt;
  logic          we_nxt;
  logic [31:0]   addr_nxt, data_nxt;
  logic          accept;
  logic [15:0]   len_in;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]    csum, csum_nxt;
`endif

  always_comb begin
    in_ready = 1'b0;
    if (!reset && !start) begin
      case (state)
        IDLE, LEN0, LEN1, DATA: in_ready = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK:                  in_ready = 1'b1;
`endif
        default:                in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;
  assign len_in = {in_data, len_lo};

  always_comb begin
    state_nxt      = state;
    len_lo_nxt     = len_lo;
    len_nxt        = len_q;
    word_index_nxt = word_index;
    byte_cnt_nxt   = byte_cnt;
    word_buf_nxt   = word_buf;
    we_nxt         = 1'b0;
    addr_nxt       = imem_address;
    data_nxt       = imem_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    csum_nxt       = csum;
`endif
    if (start) begin
      state_nxt      = IDLE;
      word_index_nxt = '0;
      byte_cnt_nxt   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_nxt       = '0;
`endif
    end else begin
      case (state)
        IDLE: if (accept && in_data == 8'hA5) state_nxt = LEN0;
        LEN0: if (accept) begin
          len_lo_nxt = in_data;
          state_nxt  = LEN1;
        end
        LEN1: if (accept) begin
          len_nxt        = IW'(len_in);
          word_index_nxt = '0;
          byte_cnt_nxt   = '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_nxt       = '0;
`endif
          if (32'(len_in) > MAX_WORDS) state_nxt = ERROR;
          else if (len_in == 16'd0)    state_nxt = TAIL;
          else                         state_nxt = DATA;
        end
        DATA: if (accept) begin
          // Bytes shift in from the top, so after three bytes word_buf = {b2, b1, b0}.
          word_buf_nxt = {in_data, word_buf[23:8]};
          byte_cnt_nxt = byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          csum_nxt     = csum ^ in_data;
`endif
          if (byte_cnt == 2'd3) begin
            state_nxt = WRITE;
            we_nxt    = 1'b1;
            addr_nxt  = {{(30-IW){1'b0}}, word_index, 2'b00};
            data_nxt  = {in_data, word_buf};
          end
        end
        WRITE: begin
          word_index_nxt = word_index + IW'(1);
          state_nxt      = (word_index + IW'(1) == len_q) ? TAIL : DATA;
        end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK: if (accept) state_nxt = (in_data == csum) ? DONE : ERROR;
`endif
        DONE, ERROR: state_nxt = state;
        default:     state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      len_lo       <= '0;
      len_q        <= '0;
      word_index   <= '0;
      byte_cnt     <= '0;
      word_buf     <= '0;
      imem_we      <= 1'b0;
      imem_address <= '0;
      imem_data    <= '0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state        <= state_nxt;
      len_lo       <= len_lo_nxt;
      len_q        <= len_nxt;
      word_index   <= word_index_nxt;
      byte_cnt     <= byte_cnt_nxt;
      word_buf     <= word_buf_nxt;
      imem_we      <= we_nxt;
      imem_address <= addr_nxt;
      imem_data    <= data_nxt;
      // Flags are registered from the next state so they line up with it.
      cpu_hold     <= (state_nxt != DONE);
      done         <= (state_nxt == DONE);
      error        <= (state_nxt == ERROR);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum         <= csum_nxt;
`endif
    end
  end
endmodule
